// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory (sub-word lanes, RMW stores, alignment check).
// Latency: done 2 cycles after accept (load, word store, misaligned), 3 for byte/half store.
// Backpressure: reqReady only in IDLE. Optional LSU_PERF_COUNT_EN adds loadCount/storeCount.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqUnsigned,
  input  logic [31:0]       reqAddr,
  input  logic [31:0]       reqWriteData,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       loadData,
  output logic [31:0]       memAddr,
  output logic [31:0]       memWriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [31:0]       memReadData
`ifdef LSU_PERF_COUNT_EN
  ,
  output logic [31:0]       loadCount,
  output logic [31:0]       storeCount
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;

  logic        accept;
  logic        bad_req;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept  = reqValid && reqReady;
  assign bad_req = (reqSize == 2'b11) ||
                   (reqSize == 2'b01 && reqAddr[0]) ||
                   (reqSize == 2'b10 && reqAddr[1:0] != 2'b00);
  assign memAddr = {{(32-(ADDR_W-2)){1'b0}}, addr_q[ADDR_W-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_req)                state_nxt = ERR;
          else if (!reqWrite)         state_nxt = LOAD;
          else if (reqSize == 2'b10)  state_nxt = STORE;
          else                        state_nxt = RMW_RD;
        end
      end
      RMW_RD:  state_nxt = RMW_WR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reqReady = (state == IDLE);
    memRead  = (state == LOAD)  || (state == RMW_RD);
    memWrite = (state == STORE) || (state == RMW_WR);
  end

  // Lane extraction for loads and lane merge for sub-word stores, both off the captured address.
  always_comb begin
    case (addr_q[1:0])
      2'd1:    rd_byte = memReadData[15:8];
      2'd2:    rd_byte = memReadData[23:16];
      2'd3:    rd_byte = memReadData[31:24];
      default: rd_byte = memReadData[7:0];
    endcase
    rd_half = addr_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_ext = memReadData;
    endcase
    merged = memReadData;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      memWriteData <= '0;
      loadData     <= '0;
      done         <= 1'b0;
      misaligned   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= reqAddr[ADDR_W-1:0];
        size_q  <= reqSize;
        uns_q   <= reqUnsigned;
        wdata_q <= reqWriteData;
        if (reqWrite && reqSize == 2'b10 && !bad_req) memWriteData <= reqWriteData;
      end
      if (state == RMW_RD) memWriteData <= merged;
      if (state == LOAD)   loadData     <= load_ext;
      done       <= (state == LOAD) || (state == STORE) || (state == RMW_WR) || (state == ERR);
      misaligned <= (state == ERR);
    end
  end

`ifdef LSU_PERF_COUNT_EN
  // Counted on the completing edge so the totals move together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadCount  <= '0;
      storeCount <= '0;
    end else begin
      if (state == LOAD) loadCount <= loadCount + 32'd1;
      if (state == STORE || state == RMW_WR) storeCount <= storeCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array reference memory and arithmetic lane model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWriteData;
  logic        done, misaligned, memRead, memWrite;
  logic [31:0] loadData, memAddr, memWriteData, memReadData;
`ifdef LSU_PERF_COUNT_EN
  logic [31:0] loadCount, storeCount;
`endif

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        init_we;
  logic [5:0]  init_idx;
  logic [31:0] init_val;
  logic [31:0] exp_ld;
  int          exp_loads, exp_stores;
  int          n_checks, n_fail;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWriteData(reqWriteData),
    .done(done), .misaligned(misaligned), .loadData(loadData),
    .memAddr(memAddr), .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
    .memReadData(memReadData)
`ifdef LSU_PERF_COUNT_EN
    , .loadCount(loadCount), .storeCount(storeCount)
`endif
  );

  assign memReadData = mem[memAddr[5:0]];

  always @(posedge clk) begin
    if (init_we)       mem[init_idx] <= init_val;
    else if (memWrite) mem[memAddr[5:0]] <= memWriteData;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word, nw, mask;
    logic [5:0]  idx;
    logic        mis;
    int          sh, lat, rd, wr, exp_lat, exp_rd, exp_wr;
    idx  = a[7:2];
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    word = ref_mem[idx];
    nw   = word;
    sh   = 8 * int'(a[1:0]);
    if (mis) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 0;
    end else if (!w) begin
      exp_lat = 2; exp_rd = 1; exp_wr = 0;
      if (sz == 2'b00) begin
        exp_ld = (word >> sh) & 32'hFF;
        if (!u && exp_ld[7]) exp_ld = exp_ld | 32'hFFFFFF00;
      end else if (sz == 2'b01) begin
        exp_ld = (word >> (16 * int'(a[1]))) & 32'hFFFF;
        if (!u && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF0000;
      end else begin
        exp_ld = word;
      end
      exp_loads++;
    end else begin
      exp_stores++;
      if (sz == 2'b10) begin
        nw = d; exp_lat = 2; exp_rd = 0; exp_wr = 1;
      end else begin
        mask = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        if (sz == 2'b01) sh = 16 * int'(a[1]);
        nw = (word & ~(mask << sh)) | ((d & mask) << sh);
        exp_lat = 3; exp_rd = 1; exp_wr = 1;
      end
      ref_mem[idx] = nw;
    end

    check_eq("ready", 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u; reqAddr = a; reqWriteData = d;
    @(negedge clk);
    lat = 1; rd = 0; wr = 0;
    while (!done && lat < 12) begin
      if (memRead || memWrite) check_eq("mem_addr", memAddr, {26'b0, idx});
      if (memWrite) check_eq("mem_wdata", memWriteData, nw);
      if (memRead && memWrite) check_eq("rd_wr_both", 32'd1, 32'd0);
      rd += int'(memRead);
      wr += int'(memWrite);
      reqValid = 1'($urandom); reqWrite = 1'($urandom); reqSize = 2'($urandom);
      reqUnsigned = 1'($urandom); reqAddr = $urandom; reqWriteData = $urandom;
      @(negedge clk);
      lat++;
    end
    reqValid = 1'b0;
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("done", 32'(done), 32'd1);
    check_eq("misaligned", 32'(misaligned), 32'(mis));
    check_eq("load_data", loadData, exp_ld);
    check_eq("read_cycles", 32'(rd), 32'(exp_rd));
    check_eq("write_cycles", 32'(wr), 32'(exp_wr));
  endtask

  initial begin
    logic        w, u;
    logic [1:0]  sz;
    logic [31:0] a;
    n_checks = 0; n_fail = 0; exp_ld = 0; exp_loads = 0; exp_stores = 0;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 0; reqWriteData = 0; init_we = 1'b0; init_idx = 0; init_val = 0;
    #2;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_mis", 32'(misaligned), 32'd0);
    check_eq("rst_rdwr", {30'b0, memRead, memWrite}, 32'd0);
    check_eq("rst_addr", memAddr, 32'd0);
    check_eq("rst_wdata", memWriteData, 32'd0);
    check_eq("rst_ld", loadData, 32'd0);
    check_eq("rst_ready", 32'(reqReady), 32'd1);
    for (int i = 0; i < 64; i++) begin
      init_idx = 6'(i); init_val = $urandom; ref_mem[i] = init_val; init_we = 1'b1;
      @(negedge clk);
    end
    init_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("tp_word", loadData, 32'hDEADBEEF);
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check_eq("tp_sbyte", loadData, 32'hFFFFFFDE);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check_eq("tp_ubyte", loadData, 32'h000000DE);
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check_eq("tp_shalf", loadData, 32'hFFFFBEEF);
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("tp_rmw", loadData, 32'hDEAD55EF);
    run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    run_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check_eq("tp_err_ld", loadData, 32'hDEAD55EF);
    run_req(1'b0, 2'b10, 1'b0, 32'h110, 32'h0);
    check_eq("tp_wrap", loadData, 32'hDEAD55EF);

    // Reset in the middle of a byte store's read cycle.
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0;
    reqAddr = 32'h12; reqWriteData = 32'hAA;
    @(negedge clk);
    check_eq("rmw_rd_cycle", 32'(memRead), 32'd1);
    rst_n = 1'b0;
    reqValid = 1'b0;
    #1;
    check_eq("mid_rst_rdwr", {30'b0, memRead, memWrite}, 32'd0);
    check_eq("mid_rst_flags", {30'b0, done, misaligned}, 32'd0);
    check_eq("mid_rst_addr", memAddr, 32'd0);
    check_eq("mid_rst_wdata", memWriteData, 32'd0);
    check_eq("mid_rst_ld", loadData, 32'd0);
    exp_ld = 0; exp_loads = 0; exp_stores = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_nowr", 32'(memWrite), 32'd0);
      check_eq("post_rst_ready", 32'(reqReady), 32'd1);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("post_rst_word", loadData, 32'hDEAD55EF);

    // Back-to-back: load, store, load, each accepted in its predecessor's done cycle.
    run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    run_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D);
    run_req(1'b0, 2'b01, 1'b0, 32'h26, 32'h0);
`ifdef LSU_PERF_COUNT_EN
    check_eq("b2b_loads", loadCount, 32'd3);
    check_eq("b2b_stores", storeCount, 32'd1);
`endif

    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom);
      sz = 2'($urandom);
      u  = 1'($urandom);
      a  = 32'($urandom_range(511, 0));
      if ($urandom_range(3, 0) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      run_req(w, sz, u, a, $urandom);
      if ($urandom_range(3, 0) == 0) begin
        @(negedge clk);
        check_eq("idle_done", 32'(done), 32'd0);
      end
    end

`ifdef LSU_PERF_COUNT_EN
    check_eq("load_count", loadCount, 32'(exp_loads));
    check_eq("store_count", storeCount, 32'(exp_stores));
`endif
    @(negedge clk);
    for (int i = 0; i < 64; i++) check_eq("mem_final", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
